// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mole_game_ctrl
//  Description : Whack-A-Mole game phase FSM, countdown, mole placement, score.
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_game_ctrl #(
    parameter int CLK_DIV    = 100_000_000,
    parameter int GAME_TIME  = 30,
    parameter int MOLE_TICKS = 3,
    parameter int NUM_MOLES  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] btn,
    output logic [1:0]           select,
    output logic [31:0]          score,
    output logic [7:0]           time_left,
    output logic [NUM_MOLES-1:0] mole
);

    localparam int c_IDX_W   = $clog2(NUM_MOLES);
    localparam int c_DIV_W   = $clog2(CLK_DIV);
    localparam int c_DWELL_W = $clog2(MOLE_TICKS + 1);
    localparam logic [NUM_MOLES-1:0] c_MOLE_ONE = {{(NUM_MOLES-1){1'b0}}, 1'b1};
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    state_t                 r_state;
    logic [15:0]            r_lfsr;
    logic [c_IDX_W-1:0]     r_idx;
    logic [NUM_MOLES-1:0]   r_mole;
    logic [c_DIV_W-1:0]     r_presc;
    logic [c_DWELL_W-1:0]   r_dwell;
    logic [31:0]            r_score;
    logic [7:0]             r_time;

    logic                   w_fb;
    logic [c_IDX_W-1:0]     w_cand_raw;
    logic [c_IDX_W-1:0]     w_cand;
    logic [NUM_MOLES-1:0]   w_cand_hot;
    logic                   w_tick;
    logic                   w_hit;
    logic                   w_reloc;

    assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cand_raw = r_lfsr[c_IDX_W-1:0];
    // Never re-place the mole where it already is; power-of-two count makes +1 wrap for free.
    assign w_cand     = (w_cand_raw == r_idx) ? w_cand_raw + 1'b1 : w_cand_raw;
    assign w_cand_hot = c_MOLE_ONE << w_cand;
    assign w_tick     = (r_presc == c_DIV_W'(CLK_DIV - 1));
    assign w_hit      = |(btn & r_mole);
    assign w_reloc    = w_hit || (w_tick && (r_dwell == c_DWELL_W'(MOLE_TICKS - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_lfsr  <= c_LFSR_SEED;
            r_idx   <= '0;
            r_mole  <= '0;
            r_presc <= '0;
            r_dwell <= '0;
            r_score <= '0;
            r_time  <= 8'(GAME_TIME);
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    r_mole <= '0;
                    if (start) begin
                        r_state <= ST_PLAY;
                        r_score <= '0;
                        r_time  <= 8'(GAME_TIME);
                        r_presc <= '0;
                        r_dwell <= '0;
                        r_idx   <= w_cand;
                        r_mole  <= w_cand_hot;
                    end
                end
                ST_PLAY: begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    if (w_hit && (r_score != 32'hFFFF_FFFF))
                        r_score <= r_score + 32'd1;
                    // The final tick wins over any relocation: the board goes dark on that edge.
                    if (w_tick && (r_time == 8'd1)) begin
                        r_time  <= 8'd0;
                        r_state <= ST_OVER;
                        r_mole  <= '0;
                        r_dwell <= '0;
                    end else begin
                        if (w_tick)
                            r_time <= r_time - 8'd1;
                        if (w_reloc) begin
                            r_idx   <= w_cand;
                            r_mole  <= w_cand_hot;
                            r_dwell <= '0;
                        end else if (w_tick) begin
                            r_dwell <= r_dwell + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_mole  <= '0;
                end
            endcase
        end
    end

    assign select    = r_state;
    assign score     = r_score;
    assign time_left = r_time;
    assign mole      = r_mole;

endmodule
`default_nettype wire
